state_array_loader: RTL and testbench
=====================================

STATE_ARRAY_LOADER -- requirements
Module: state_array_loader

Interface
REQ-001 SHALL have parameter COL_MAJOR, default 1; 1 = AES column-major byte order, 0 = row-major.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port clear, input, 1 bit: synchronous abort of the current fill.
REQ-005 SHALL have port in_valid, input, 1 bit: in_byte carries a valid byte.
REQ-006 SHALL have port in_byte, input, [8:1]: serial state byte.
REQ-007 SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: the full 4x4 array is presented.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream consumes the array (e.g. the XOR stage).
REQ-010 SHALL have ports output_array_rowR_colC, output, [8:1], R,C in 1..4 (16 ports): registered state bytes.
REQ-011 SHALL have port byte_count, output, [3:0]: index of the next byte to be written.

Function
REQ-012 SHALL implement two states: LOAD (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-013 SHALL accept a byte only on a cycle with in_valid=1 and in_ready=1.
REQ-014 SHALL write an accepted byte at index i=byte_count: COL_MAJOR=1 -> row=i[1:0]+1, col=i[3:2]+1; COL_MAJOR=0 -> row=i[3:2]+1, col=i[1:0]+1.
REQ-015 SHALL increment byte_count by 1 per accepted byte, modulo 16; accepting index 15 wraps it to 0.
REQ-016 SHALL move LOAD->FULL on the edge that accepts index 15, so out_valid=1 in the following cycle (1-cycle latency after the 16th byte).
REQ-017 SHALL move FULL->LOAD on any edge where out_valid=1 and out_ready=1; in_ready=1 from the next cycle.
REQ-018 SHALL ignore in_valid while in FULL; no byte is lost or overwritten, and the upstream must hold it.
REQ-019 SHALL NOT bypass: a handoff cycle in FULL does not also accept a byte.
REQ-020 SHALL keep every output_array port stable while in FULL and after handoff, until that cell is rewritten.
REQ-021 SHALL, on clear=1 at a rising edge, force state LOAD, byte_count=0 and all 16 array bytes to 8'h00, regardless of state.
REQ-022 SHALL give clear priority over a byte accept and over a handoff in the same cycle.
REQ-023 SHALL leave cells not yet rewritten at their previous values during a partial fill.
REQ-024 SHALL treat out_ready as don't-care in LOAD.
REQ-025 SHALL keep all outputs free of combinational paths from inputs; in_ready and out_valid are decoded from state only.

Reset
REQ-026 SHALL, while rst_n=0 and independent of clk, force state LOAD, byte_count=0, all output_array bytes 8'h00, out_valid=0 and in_ready=1.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.
REQ-028 SHALL discard a partial fill or a pending FULL array when reset asserts mid-operation.

Verification
REQ-029 Stream 00,11,22,...,FF with in_valid held high and out_ready=0, COL_MAJOR=1 -> row1_col1=00, row2_col1=11, row4_col1=33, row1_col2=44, row4_col4=FF; out_valid=1 exactly one cycle after the 16th accept; in_ready=0.
REQ-030 Same stream with COL_MAJOR=0 -> row1_col2=11, row2_col1=44, row4_col4=FF.
REQ-031 Stay in FULL for 5 cycles with in_valid=1, in_byte=AA -> array unchanged and byte_count=0. Then pulse out_ready -> in_ready=1 next cycle, and the next accepted byte lands in row1_col1.
REQ-032 Accept 7 bytes, then assert clear together with in_valid=1 -> byte_count=0, all cells 00, no byte written that cycle.
REQ-033 Assert rst_n=0 asynchronously mid-cycle after 10 bytes -> outputs reset immediately with no clk edge: byte_count=0, out_valid=0, in_ready=1.
REQ-034 Random in_valid/out_ready back-pressure over 100 arrays -> every output array matches a scoreboard, with no dropped or duplicated bytes.

Source files
------------

// File: rtl/state_array_loader.sv
// Serial-to-parallel loader: collects 16 bytes into a 4x4 state array and
// hands the full array downstream with a valid/ready handshake.
module state_array_loader #(
   parameter int COL_MAJOR = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       in_valid,
   input  logic [8:1] in_byte,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:1] output_array_row1_col1,
   output logic [8:1] output_array_row1_col2,
   output logic [8:1] output_array_row1_col3,
   output logic [8:1] output_array_row1_col4,
   output logic [8:1] output_array_row2_col1,
   output logic [8:1] output_array_row2_col2,
   output logic [8:1] output_array_row2_col3,
   output logic [8:1] output_array_row2_col4,
   output logic [8:1] output_array_row3_col1,
   output logic [8:1] output_array_row3_col2,
   output logic [8:1] output_array_row3_col3,
   output logic [8:1] output_array_row3_col4,
   output logic [8:1] output_array_row4_col1,
   output logic [8:1] output_array_row4_col2,
   output logic [8:1] output_array_row4_col3,
   output logic [8:1] output_array_row4_col4,
   output logic [3:0] byte_count
);

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_count;
   logic [7:0] r_cell [0:15];   // stored row-major: (row-1)*4 + (col-1)
   logic       w_accept;
   logic [3:0] w_cell_idx;

   assign w_accept = (r_state == ST_LOAD) && in_valid;

   // Map the serial byte index onto the row-major cell storage
   always_comb begin
      w_cell_idx = r_count;
      if (COL_MAJOR != 0) begin
         w_cell_idx = {r_count[1:0], r_count[3:2]};
      end else begin
         w_cell_idx = r_count;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_LOAD: begin
            if (w_accept && (r_count == 4'd15)) begin
               w_state_nxt = ST_FULL;
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               w_state_nxt = ST_LOAD;
            end else begin
               w_state_nxt = ST_FULL;
            end
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // State register; clear outranks both accept and handoff
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_LOAD;
      end else if (clear) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Byte counter and cell storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 4'd0;
         for (int k = 0; k < 16; k++) begin
            r_cell[k] <= 8'h00;
         end
      end else if (clear) begin
         r_count <= 4'd0;
         for (int k = 0; k < 16; k++) begin
            r_cell[k] <= 8'h00;
         end
      end else if (w_accept) begin
         r_cell[w_cell_idx] <= in_byte;
         r_count            <= r_count + 4'd1;
      end else begin
         r_count <= r_count;
      end
   end

   assign in_ready   = (r_state == ST_LOAD);
   assign out_valid  = (r_state == ST_FULL);
   assign byte_count = r_count;

   assign output_array_row1_col1 = r_cell[0];
   assign output_array_row1_col2 = r_cell[1];
   assign output_array_row1_col3 = r_cell[2];
   assign output_array_row1_col4 = r_cell[3];
   assign output_array_row2_col1 = r_cell[4];
   assign output_array_row2_col2 = r_cell[5];
   assign output_array_row2_col3 = r_cell[6];
   assign output_array_row2_col4 = r_cell[7];
   assign output_array_row3_col1 = r_cell[8];
   assign output_array_row3_col2 = r_cell[9];
   assign output_array_row3_col3 = r_cell[10];
   assign output_array_row3_col4 = r_cell[11];
   assign output_array_row4_col1 = r_cell[12];
   assign output_array_row4_col2 = r_cell[13];
   assign output_array_row4_col3 = r_cell[14];
   assign output_array_row4_col4 = r_cell[15];

endmodule

// File: tb/tb_state_array_loader.sv
// Bench for state_array_loader: one column-major and one row-major instance
// driven in lockstep and compared against a behavioural model every cycle.
module tb_state_array_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic [8:1] in_byte;
   logic       out_ready;

   logic       in_ready1, out_valid1, in_ready0, out_valid0;
   logic [3:0] byte_count1, byte_count0;
   wire  [8:1] m1 [1:4][1:4];
   wire  [8:1] m0 [1:4][1:4];

   int n_checks = 0;
   int n_pass   = 0;

   // behavioural model: expected cells indexed [row-1][col-1]
   logic [7:0] e1 [0:3][0:3];
   logic [7:0] e0 [0:3][0:3];
   int         m_cnt;
   bit         m_full;
   bit         m_acc;
   int         m_handoffs;

   always #5 clk = ~clk;

   state_array_loader #(.COL_MAJOR(1)) u_cm (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_byte(in_byte),
      .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
      .output_array_row1_col1(m1[1][1]), .output_array_row1_col2(m1[1][2]),
      .output_array_row1_col3(m1[1][3]), .output_array_row1_col4(m1[1][4]),
      .output_array_row2_col1(m1[2][1]), .output_array_row2_col2(m1[2][2]),
      .output_array_row2_col3(m1[2][3]), .output_array_row2_col4(m1[2][4]),
      .output_array_row3_col1(m1[3][1]), .output_array_row3_col2(m1[3][2]),
      .output_array_row3_col3(m1[3][3]), .output_array_row3_col4(m1[3][4]),
      .output_array_row4_col1(m1[4][1]), .output_array_row4_col2(m1[4][2]),
      .output_array_row4_col3(m1[4][3]), .output_array_row4_col4(m1[4][4]),
      .byte_count(byte_count1)
   );

   state_array_loader #(.COL_MAJOR(0)) u_rm (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_byte(in_byte),
      .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready),
      .output_array_row1_col1(m0[1][1]), .output_array_row1_col2(m0[1][2]),
      .output_array_row1_col3(m0[1][3]), .output_array_row1_col4(m0[1][4]),
      .output_array_row2_col1(m0[2][1]), .output_array_row2_col2(m0[2][2]),
      .output_array_row2_col3(m0[2][3]), .output_array_row2_col4(m0[2][4]),
      .output_array_row3_col1(m0[3][1]), .output_array_row3_col2(m0[3][2]),
      .output_array_row3_col3(m0[3][3]), .output_array_row3_col4(m0[3][4]),
      .output_array_row4_col1(m0[4][1]), .output_array_row4_col2(m0[4][2]),
      .output_array_row4_col3(m0[4][3]), .output_array_row4_col4(m0[4][4]),
      .byte_count(byte_count0)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [127:0] dut_arr(input bit cm);
      logic [127:0] v = '0;
      for (int r = 1; r <= 4; r++)
         for (int c = 1; c <= 4; c++)
            v[((r-1)*4 + (c-1))*8 +: 8] = cm ? m1[r][c] : m0[r][c];
      return v;
   endfunction

   function automatic logic [127:0] exp_arr(input bit cm);
      logic [127:0] v = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            v[(r*4 + c)*8 +: 8] = cm ? e1[r][c] : e0[r][c];
      return v;
   endfunction

   task automatic model_clear();
      m_cnt  = 0;
      m_full = 0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            e1[r][c] = 8'h00;
            e0[r][c] = 8'h00;
         end
   endtask

   task automatic model_update(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
      m_acc = 0;
      if (clr) begin
         model_clear();
      end else if (!m_full && v) begin
         m_acc = 1;
         e1[m_cnt % 4][m_cnt / 4] = b;
         e0[m_cnt / 4][m_cnt % 4] = b;
         if (m_cnt == 15) m_full = 1;
         m_cnt = (m_cnt + 1) % 16;
      end else if (m_full && rdy) begin
         m_full = 0;
         m_handoffs++;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".in_ready_cm"},  {127'd0, in_ready1},  {127'd0, !m_full});
      chk({tag, ".out_valid_cm"}, {127'd0, out_valid1}, {127'd0, m_full});
      chk({tag, ".count_cm"},     {124'd0, byte_count1}, 128'(m_cnt));
      chk({tag, ".in_ready_rm"},  {127'd0, in_ready0},  {127'd0, !m_full});
      chk({tag, ".out_valid_rm"}, {127'd0, out_valid0}, {127'd0, m_full});
      chk({tag, ".count_rm"},     {124'd0, byte_count0}, 128'(m_cnt));
      chk({tag, ".array_cm"},     dut_arr(1'b1), exp_arr(1'b1));
      chk({tag, ".array_rm"},     dut_arr(1'b0), exp_arr(1'b0));
   endtask

   task automatic step(input string tag, input logic v, input logic [7:0] b,
                       input logic rdy, input logic clr);
      in_valid  = v;
      in_byte   = b;
      out_ready = rdy;
      clear     = clr;
      model_update(v, b, rdy, clr);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // called at posedge+1: reset lands mid-cycle, checked before any edge
   task automatic async_reset(input string tag);
      in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check_all(tag);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] pend;
      int         target;
      int         cyc;

      m_handoffs = 0;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
      model_clear();
      #12;
      check_all("reset");
      rst_n = 1'b1;

      // 00,11,...,FF with out_ready low
      for (int i = 0; i < 16; i++) step("stream", 1'b1, 8'(i * 17), 1'b0, 1'b0);
      chk("cm_r1c1", {120'd0, m1[1][1]}, 128'h00);
      chk("cm_r2c1", {120'd0, m1[2][1]}, 128'h11);
      chk("cm_r4c1", {120'd0, m1[4][1]}, 128'h33);
      chk("cm_r1c2", {120'd0, m1[1][2]}, 128'h44);
      chk("cm_r4c4", {120'd0, m1[4][4]}, 128'hFF);
      chk("rm_r1c2", {120'd0, m0[1][2]}, 128'h11);
      chk("rm_r2c1", {120'd0, m0[2][1]}, 128'h44);
      chk("rm_r4c4", {120'd0, m0[4][4]}, 128'hFF);
      chk("full_ov", {127'd0, out_valid1}, 128'd1);
      chk("full_ir", {127'd0, in_ready1}, 128'd0);

      // hold in FULL while upstream pushes AA, then hand off
      for (int i = 0; i < 5; i++) step("hold", 1'b1, 8'hAA, 1'b0, 1'b0);
      chk("hold_r1c1", {120'd0, m1[1][1]}, 128'h00);
      chk("hold_cnt", {124'd0, byte_count1}, 128'd0);
      step("handoff", 1'b1, 8'hAA, 1'b1, 1'b0);
      chk("handoff_ir", {127'd0, in_ready1}, 128'd1);
      step("after", 1'b1, 8'h5A, 1'b0, 1'b0);
      chk("after_r1c1_cm", {120'd0, m1[1][1]}, 128'h5A);
      chk("after_r1c1_rm", {120'd0, m0[1][1]}, 128'h5A);

      // 7 bytes in total, then clear wins over an accept
      for (int i = 0; i < 6; i++) step("part", 1'b1, 8'($urandom), 1'b0, 1'b0);
      step("clear_accept", 1'b1, 8'hC3, 1'b0, 1'b1);
      chk("clear_cnt", {124'd0, byte_count1}, 128'd0);
      chk("clear_cells", dut_arr(1'b1), 128'd0);

      // clear wins over a handoff from FULL
      for (int i = 0; i < 16; i++) step("fill2", 1'b1, 8'($urandom), 1'b0, 1'b0);
      step("clear_full", 1'b1, 8'h77, 1'b1, 1'b1);

      // async reset after 10 bytes, and with a pending full array
      for (int i = 0; i < 10; i++) step("pre_rst", 1'b1, 8'($urandom), 1'b0, 1'b0);
      async_reset("rst_partial");
      step("post_rst", 1'b1, 8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) step("fill3", 1'b1, 8'($urandom), 1'b0, 1'b0);
      async_reset("rst_full");

      // random back-pressure over 100 arrays
      target = m_handoffs + 100;
      cyc    = 0;
      pend   = 8'($urandom);
      while (m_handoffs < target && cyc < 20000) begin
         step("rand", 1'($urandom_range(0, 3) != 0), pend, 1'($urandom_range(0, 1)), 1'b0);
         if (m_acc) pend = 8'($urandom);
         cyc++;
      end
      chk("rand_arrays", 128'(m_handoffs), 128'(target));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
